// File: rtl/wb_stage_param_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_param_if
// Brief    : MEM-to-WB bundle plus the registered and forwarding result
//            signals of the write-back stage.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_stage_param_if #(
    parameter int XLEN         = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int RETIRE_CNT_W = 64
) ();
    logic                    valid_in;
    logic                    stall;
    logic                    flush;
    logic                    reg_wen_in;
    logic [1:0]              wb_sel_in;
    logic [2:0]              funct3_in;
    logic [XLEN-1:0]         mem_rdata_in;
    logic [XLEN-1:0]         alu_result_in;
    logic [XLEN-1:0]         pc_plus4_in;
    logic [XLEN-1:0]         csr_rdata_in;
    logic [REG_ADDR_W-1:0]   addr_d_in;

    logic                    valid_out;
    logic                    reg_wen_out;
    logic [REG_ADDR_W-1:0]   addr_d_out;
    logic [XLEN-1:0]         data_wb_out;
    logic                    fwd_wen;
    logic [REG_ADDR_W-1:0]   fwd_addr;
    logic [XLEN-1:0]         fwd_data;
    logic                    misalign_err;
    logic [RETIRE_CNT_W-1:0] retire_cnt;

    // Pipeline side: drives MEM results, observes write-back results.
    modport master (
        output valid_in, stall, flush, reg_wen_in, wb_sel_in, funct3_in,
               mem_rdata_in, alu_result_in, pc_plus4_in, csr_rdata_in, addr_d_in,
        input  valid_out, reg_wen_out, addr_d_out, data_wb_out,
               fwd_wen, fwd_addr, fwd_data, misalign_err, retire_cnt
    );

    // Write-back stage side.
    modport slave (
        input  valid_in, stall, flush, reg_wen_in, wb_sel_in, funct3_in,
               mem_rdata_in, alu_result_in, pc_plus4_in, csr_rdata_in, addr_d_in,
        output valid_out, reg_wen_out, addr_d_out, data_wb_out,
               fwd_wen, fwd_addr, fwd_data, misalign_err, retire_cnt
    );
endinterface : wb_stage_param_if
`default_nettype wire

// File: rtl/wb_stage_param.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_param
// Brief    : RV32I write-back stage: load formatting, source select, x0 and
//            misalignment gating, registered result and zero-latency forward.
//            Optional retire counter enabled by macro WB_RETIRE_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage_param #(
    parameter int XLEN         = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int RETIRE_CNT_W = 64
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    wb_stage_param_if.slave   bus
);

    localparam logic [1:0] c_SEL_MEM = 2'b00;
    localparam logic [1:0] c_SEL_ALU = 2'b01;
    localparam logic [1:0] c_SEL_PC4 = 2'b10;
    localparam logic [1:0] c_SEL_CSR = 2'b11;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    logic [1:0]      w_off;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_wb_data;
    logic            w_is_load;
    logic            w_misaligned;
    logic            w_eff_wen;

    assign w_off     = bus.alu_result_in[1:0];
    assign w_is_load = bus.valid_in && (bus.wb_sel_in == c_SEL_MEM);

    always_comb begin
        w_byte = bus.mem_rdata_in[7:0];
        case (w_off)
            2'd0:    w_byte = bus.mem_rdata_in[7:0];
            2'd1:    w_byte = bus.mem_rdata_in[15:8];
            2'd2:    w_byte = bus.mem_rdata_in[23:16];
            default: w_byte = bus.mem_rdata_in[31:24];
        endcase
    end

    assign w_half = w_off[1] ? bus.mem_rdata_in[31:16] : bus.mem_rdata_in[15:0];

    // Fill with the extension bit first, then overlay the selected lane; this
    // keeps one form valid for both XLEN=32 and XLEN=64.
    always_comb begin
        w_load = bus.mem_rdata_in;
        case (bus.funct3_in)
            c_F3_LB: begin
                w_load      = {XLEN{w_byte[7]}};
                w_load[7:0] = w_byte;
            end
            c_F3_LBU: begin
                w_load      = '0;
                w_load[7:0] = w_byte;
            end
            c_F3_LH: begin
                w_load       = {XLEN{w_half[15]}};
                w_load[15:0] = w_half;
            end
            c_F3_LHU: begin
                w_load       = '0;
                w_load[15:0] = w_half;
            end
            c_F3_LW: begin
                w_load       = {XLEN{bus.mem_rdata_in[31]}};
                w_load[31:0] = bus.mem_rdata_in[31:0];
            end
            default: w_load = bus.mem_rdata_in;
        endcase
    end

    always_comb begin
        w_wb_data = w_load;
        case (bus.wb_sel_in)
            c_SEL_MEM: w_wb_data = w_load;
            c_SEL_ALU: w_wb_data = bus.alu_result_in;
            c_SEL_PC4: w_wb_data = bus.pc_plus4_in;
            c_SEL_CSR: w_wb_data = bus.csr_rdata_in;
            default:   w_wb_data = w_load;
        endcase
    end

    always_comb begin
        w_misaligned = 1'b0;
        if (w_is_load) begin
            case (bus.funct3_in)
                c_F3_LH, c_F3_LHU: w_misaligned = w_off[0];
                c_F3_LW:           w_misaligned = (w_off != 2'b00);
                default:           w_misaligned = 1'b0;
            endcase
        end
    end

    assign w_eff_wen = bus.valid_in && bus.reg_wen_in &&
                       (bus.addr_d_in != '0) && !w_misaligned;

    assign bus.fwd_wen  = w_eff_wen;
    assign bus.fwd_addr = bus.addr_d_in;
    assign bus.fwd_data = w_wb_data;

    logic                  valid_q;
    logic                  reg_wen_q;
    logic [REG_ADDR_W-1:0] addr_d_q;
    logic [XLEN-1:0]       data_wb_q;
    logic                  misalign_q;

    // Priority: reset, then flush (bubble, even when stalled), then stall.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            reg_wen_q  <= 1'b0;
            addr_d_q   <= '0;
            data_wb_q  <= '0;
            misalign_q <= 1'b0;
        end else if (bus.flush) begin
            valid_q    <= 1'b0;
            reg_wen_q  <= 1'b0;
            addr_d_q   <= '0;
            data_wb_q  <= '0;
            misalign_q <= 1'b0;
        end else if (!bus.stall) begin
            valid_q    <= bus.valid_in;
            reg_wen_q  <= w_eff_wen;
            addr_d_q   <= bus.addr_d_in;
            data_wb_q  <= w_wb_data;
            misalign_q <= w_misaligned;
        end
    end

    assign bus.valid_out    = valid_q;
    assign bus.reg_wen_out  = reg_wen_q;
    assign bus.addr_d_out   = addr_d_q;
    assign bus.data_wb_out  = data_wb_q;
    assign bus.misalign_err = misalign_q;

`ifdef WB_RETIRE_CNT_EN
    logic [RETIRE_CNT_W-1:0] retire_q;
    logic [RETIRE_CNT_W-1:0] retire_d;
    logic                    w_retire;

    assign w_retire = bus.valid_in && !bus.stall && !bus.flush && !w_misaligned;
    assign retire_d = retire_q + {{(RETIRE_CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            retire_q <= '0;
        end else if (w_retire) begin
            retire_q <= retire_d;
        end
    end

    assign bus.retire_cnt = retire_q;
`else
    assign bus.retire_cnt = '0;
`endif

endmodule : wb_stage_param
`default_nettype wire

// File: doc/wb_stage_param.md
Name: wb_stage_param

Overview:
Parametrised write-back stage for the RV32I pipeline, the next generation of the existing write-back register stage. Formats load data per funct3 and byte offset. Selects the write-back source from four inputs. Gates writes to x0 and misaligned loads, and registers the result with valid/stall/flush control. Sits between MEM and the register file, and drives a combinational forwarding path to the hazard unit.

Parameters:
XLEN, 32, datapath width (32 or 64; byte/half formatting uses the low bits only)
REG_ADDR_W, 5, register-file address width
RETIRE_CNT_W, 64, width of retire counter (used only with the optional feature)

Ports:
clk  in  1  clock
reset_n  in  1  reset, synchronous, active-low
valid_in  in  1  MEM-stage instruction valid
stall  in  1  hold registered outputs
flush  in  1  kill registered outputs (insert bubble)
reg_wen_in  in  1  instruction writes rd
wb_sel_in  in  2  00 mem, 01 alu, 10 pc+4, 11 csr
funct3_in  in  3  load type
mem_rdata_in  in  XLEN  raw aligned memory word
alu_result_in  in  XLEN  ALU result / load address
pc_plus4_in  in  XLEN  link value
csr_rdata_in  in  XLEN  CSR read data
addr_d_in  in  REG_ADDR_W  rd
valid_out  out  1  registered valid
reg_wen_out  out  1  registered effective write enable
addr_d_out  out  REG_ADDR_W  registered rd
data_wb_out  out  XLEN  registered write-back data
fwd_wen  out  1  combinational effective write enable
fwd_addr  out  REG_ADDR_W  combinational rd (= addr_d_in)
fwd_data  out  XLEN  combinational write-back data
misalign_err  out  1  registered misaligned-load flag
retire_cnt  out  RETIRE_CNT_W  retired-instruction count

Behaviour:
- Byte offset off = alu_result_in[1:0].
- Load format, applied only when wb_sel_in=00:
  - 000 LB: sign-extend byte[off].
  - 100 LBU: zero-extend byte[off].
  - 001 LH: sign-extend half[off[1]].
  - 101 LHU: zero-extend half[off[1]].
  - 010 LW: low 32 bits, sign-extended to XLEN.
  - Other codes: raw mem_rdata_in.
- Misaligned: load (wb_sel_in=00 & valid_in) with LH/LHU and off[0]=1, or LW and off!=0.
- fwd_data: mux of formatted load / alu / pc+4 / csr; purely combinational, zero latency.
- eff_wen = valid_in & reg_wen_in & (addr_d_in != 0) & ~misaligned; fwd_wen = eff_wen.
- Register update, priority reset > flush > stall > load:
  - Reset: all registered outputs 0, retire_cnt 0.
  - Flush: valid_out, reg_wen_out, misalign_err, addr_d_out, data_wb_out all <= 0. Flush overrides simultaneous stall.
  - Stall (no flush): all registered outputs hold.
  - Normal: valid_out<=valid_in, reg_wen_out<=eff_wen, addr_d_out<=addr_d_in, data_wb_out<=fwd_data, misalign_err<=misaligned.
- Latency: inputs to registered outputs = 1 cycle; to fwd_* = 0 cycles.
- valid_in=0: reg_wen_out=0 next cycle; data/addr still captured (don't-care downstream).
- Reset asserted mid-stall or mid-flush: reset wins that edge.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined: retire_cnt increments by 1 on each edge where reset_n & valid_in & ~stall & ~flush & ~misaligned. Wraps modulo 2^RETIRE_CNT_W. Cleared on reset.
- Undefined: retire_cnt tied to 0, no counter logic.

Test Plan:
- Reset: reset_n=0 one edge with all inputs random -> all registered outputs 0, retire_cnt=0.
- LB: sel=00, funct3=000, mem=0x80FF7F01, alu=0x1002 -> fwd_data=0xFFFFFFFF; next edge data_wb_out=0xFFFFFFFF, reg_wen_out=1 (rd=5). LBU same -> 0x000000FF.
- Misaligned: LH at alu=0x1001 -> fwd_wen=0; next edge misalign_err=1, reg_wen_out=0. LW at alu=0x1000, mem=0x12345678 -> data 0x12345678.
- x0 gating: sel=01, alu=0xDEADBEEF, rd=0, reg_wen_in=1 -> fwd_wen=0, reg_wen_out=0, data_wb_out=0xDEADBEEF.
- Stall/flush: load sel=10 pc+4=0x104 into rd=3, then stall=1 for 3 cycles with new inputs -> outputs hold 0x104/3. Then stall=1 & flush=1 -> valid_out=0, reg_wen_out=0, data 0.
- Retire counter (WB_RETIRE_CNT_EN): 10 valid cycles with 2 stalled, 1 flushed, 1 misaligned -> retire_cnt=6. Preload to 2^64-1 via 2^64-1 cycles is infeasible, so test wrap with RETIRE_CNT_W=4: 17 retirements -> 1.
